// File: rtl/inst_load_pkg.sv
// rtl/inst_load_pkg.sv - shared types and widths for the instruction load responder
package inst_load_pkg;

    localparam int WORD_CNT_W = 16;
    localparam int DROP_CNT_W = 8;

    typedef struct packed {
        logic [29:0] addr;
        logic [31:0] data;
        logic [3:0]  be;
    } inst_wr_req_t;

    typedef enum logic {IDLE, ISSUE} issue_state_t;
    typedef enum logic {HOLD, RUN} hold_state_t;

endpackage

// File: rtl/inst_load_fifo.sv
// rtl/inst_load_fifo.sv - request FIFO exposing its head and the entry behind it
module inst_load_fifo
    import inst_load_pkg::*;
#(
    parameter int  DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH) + 1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             push,
    input  logic             pop,
    input  inst_wr_req_t     wdata,
    output inst_wr_req_t     head,
    output inst_wr_req_t     next,
    output logic             full,
    output logic             empty,
    output logic [PTR_W-1:0] count
);

    localparam int IDX_W = PTR_W - 1;

    inst_wr_req_t     mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [IDX_W-1:0] rd_idx_next;

    assign count       = wr_ptr - rd_ptr;
    assign empty       = (count == '0);
    assign full        = (count == PTR_W'(DEPTH));
    assign rd_idx_next = rd_ptr[IDX_W-1:0] + IDX_W'(1);
    // The issuer needs the second entry to sustain one beat per cycle
    assign head        = mem[rd_ptr[IDX_W-1:0]];
    assign next        = mem[rd_idx_next];

    always_ff @(posedge clk_i) begin
        if (push) begin
            mem[wr_ptr[IDX_W-1:0]] <= wdata;
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
        end
    end

endmodule

// File: rtl/inst_load_resp.sv
// rtl/inst_load_resp.sv - buffers bench instruction writes and issues them to the TCM port
module inst_load_resp
    import inst_load_pkg::*;
#(
    parameter int          FIFO_DEPTH = 4,
    parameter logic [31:0] ADDR_MIN   = 32'h0000_0000,
    parameter logic [31:0] ADDR_MAX   = 32'h0000_FFFF
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [3:0]            tb_inst_we_i,
    input  logic [31:0]           tb_inst_addr_i,
    input  logic [31:0]           tb_inst_data_i,
    input  logic                  rst_cpu_i,
    output logic                  mem_wr_o,
    output logic [31:0]           mem_addr_o,
    output logic [31:0]           mem_data_o,
    output logic [3:0]            mem_be_o,
    input  logic                  mem_accept_i,
    output logic                  cpu_rst_o,
    output logic                  load_busy_o,
    output logic [WORD_CNT_W-1:0] word_cnt_o,
    output logic [31:0]           checksum_o,
    output logic [DROP_CNT_W-1:0] drop_cnt_o,
    output logic                  overflow_o
);

    localparam int PTR_W = $clog2(FIFO_DEPTH) + 1;

    logic             wr_req;
    logic             in_range;
    logic             push;
    logic             pop;
    logic             fifo_full;
    logic             fifo_empty;
    logic [31:0]      word_addr;
    logic [PTR_W-1:0] fifo_count;
    inst_wr_req_t     req;
    inst_wr_req_t     head;
    inst_wr_req_t     next_req;
    issue_state_t     issue_state;
    hold_state_t      hold_state;

    assign wr_req    = |tb_inst_we_i;
    assign word_addr = tb_inst_addr_i & 32'hFFFF_FFFC;
    // Offset compare: below ADDR_MIN wraps to a large value, so one test covers both bounds
    assign in_range  = (word_addr - ADDR_MIN) <= (ADDR_MAX - ADDR_MIN);
    assign pop       = (issue_state == ISSUE) && mem_accept_i;
    assign push      = wr_req && in_range && (!fifo_full || pop);
    assign req       = '{addr: tb_inst_addr_i[31:2], data: tb_inst_data_i, be: tb_inst_we_i};
    assign load_busy_o = !fifo_empty;

    inst_load_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .push  (push),
        .pop   (pop),
        .wdata (req),
        .head  (head),
        .next  (next_req),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    // The presented beat stays in the FIFO until accepted
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            issue_state <= IDLE;
            mem_wr_o    <= 1'b0;
            mem_addr_o  <= '0;
            mem_data_o  <= '0;
            mem_be_o    <= '0;
        end else begin
            case (issue_state)
                IDLE: begin
                    if (!fifo_empty) begin
                        issue_state <= ISSUE;
                        mem_wr_o    <= 1'b1;
                        mem_addr_o  <= {head.addr, 2'b00};
                        mem_data_o  <= head.data;
                        mem_be_o    <= head.be;
                    end
                end
                ISSUE: begin
                    if (mem_accept_i) begin
                        if (fifo_count > PTR_W'(1)) begin
                            mem_addr_o <= {next_req.addr, 2'b00};
                            mem_data_o <= next_req.data;
                            mem_be_o   <= next_req.be;
                        end else begin
                            issue_state <= IDLE;
                            mem_wr_o    <= 1'b0;
                        end
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            hold_state <= HOLD;
            cpu_rst_o  <= 1'b1;
        end else if (rst_cpu_i) begin
            hold_state <= HOLD;
            cpu_rst_o  <= 1'b1;
        end else if (hold_state == HOLD && !load_busy_o && !mem_wr_o) begin
            hold_state <= RUN;
            cpu_rst_o  <= 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            word_cnt_o <= '0;
            checksum_o <= '0;
            drop_cnt_o <= '0;
            overflow_o <= 1'b0;
        end else begin
            if (push) begin
                word_cnt_o <= word_cnt_o + WORD_CNT_W'(1);
                checksum_o <= checksum_o ^ tb_inst_data_i;
            end
            if (wr_req && !push) begin
                if (drop_cnt_o != '1) begin
                    drop_cnt_o <= drop_cnt_o + DROP_CNT_W'(1);
                end
                if (in_range) begin
                    overflow_o <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_inst_load_resp.sv
// tb/tb_inst_load_resp.sv - self-checking bench for inst_load_resp with a queue reference model
module tb_inst_load_resp;

    localparam int          DEPTH    = 4;
    localparam logic [31:0] ADDR_MIN = 32'h0000_0000;
    localparam logic [31:0] ADDR_MAX = 32'h0000_FFFF;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b0;
    logic [3:0]  tb_inst_we_i = '0;
    logic [31:0] tb_inst_addr_i = '0;
    logic [31:0] tb_inst_data_i = '0;
    logic        rst_cpu_i = 1'b0;
    logic        mem_accept_i = 1'b0;
    logic        mem_wr_o;
    logic [31:0] mem_addr_o;
    logic [31:0] mem_data_o;
    logic [3:0]  mem_be_o;
    logic        cpu_rst_o;
    logic        load_busy_o;
    logic [15:0] word_cnt_o;
    logic [31:0] checksum_o;
    logic [7:0]  drop_cnt_o;
    logic        overflow_o;

    always #5 clk_i = ~clk_i;

    inst_load_resp dut (
        .clk_i          (clk_i),
        .rst_i          (rst_i),
        .tb_inst_we_i   (tb_inst_we_i),
        .tb_inst_addr_i (tb_inst_addr_i),
        .tb_inst_data_i (tb_inst_data_i),
        .rst_cpu_i      (rst_cpu_i),
        .mem_wr_o       (mem_wr_o),
        .mem_addr_o     (mem_addr_o),
        .mem_data_o     (mem_data_o),
        .mem_be_o       (mem_be_o),
        .mem_accept_i   (mem_accept_i),
        .cpu_rst_o      (cpu_rst_o),
        .load_busy_o    (load_busy_o),
        .word_cnt_o     (word_cnt_o),
        .checksum_o     (checksum_o),
        .drop_cnt_o     (drop_cnt_o),
        .overflow_o     (overflow_o)
    );

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  be;
    } beat_t;

    beat_t       exp_q[$];
    int          n_checks = 0;
    int          n_errors = 0;
    logic [15:0] m_words;
    logic [31:0] m_csum;
    int          m_drops;
    logic        m_ovf;
    logic        m_held;
    logic        s_wr;
    logic [31:0] s_addr;
    logic [31:0] s_data;
    logic [3:0]  s_be;
    logic        prev_stall;
    logic [31:0] p_addr;
    logic [31:0] p_data;
    logic [3:0]  p_be;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step(input logic [3:0] we, input logic [31:0] addr, input logic [31:0] data,
                        input logic acc, input logic rc);
        int          occ;
        logic        popped;
        logic [31:0] waddr;
        beat_t       b;
        tb_inst_we_i   = we;
        tb_inst_addr_i = addr;
        tb_inst_data_i = data;
        mem_accept_i   = acc;
        rst_cpu_i      = rc;
        @(negedge clk_i);
        #4;
        s_wr = mem_wr_o; s_addr = mem_addr_o; s_data = mem_data_o; s_be = mem_be_o;
        if (prev_stall) begin
            chk("stall_wr", 32'(s_wr), 32'd1);
            chk("stall_addr", s_addr, p_addr);
            chk("stall_data", s_data, p_data);
            chk("stall_be", 32'(s_be), 32'(p_be));
        end
        prev_stall = s_wr && !acc;
        p_addr = s_addr; p_data = s_data; p_be = s_be;
        occ    = exp_q.size();
        popped = s_wr && acc;
        if (popped) begin
            if (occ == 0) begin
                chk("spurious_wr", 32'(s_wr), 32'd0);
            end else begin
                b = exp_q.pop_front();
                chk("beat_addr", s_addr, b.addr);
                chk("beat_data", s_data, b.data);
                chk("beat_be", 32'(s_be), 32'(b.be));
            end
        end
        if (we != 4'h0) begin
            waddr = addr & 32'hFFFF_FFFC;
            if (longint'(waddr) < longint'(ADDR_MIN) || waddr > ADDR_MAX) begin
                m_drops++;
            end else if (occ == DEPTH && !popped) begin
                m_drops++;
                m_ovf = 1'b1;
            end else begin
                b.addr = waddr; b.data = data; b.be = we;
                exp_q.push_back(b);
                m_words = m_words + 16'd1;
                m_csum  = m_csum ^ data;
            end
        end
        if (rc) m_held = 1'b1;
        else if (occ == 0) m_held = 1'b0;
        @(posedge clk_i);
        #1;
        chk("word_cnt", 32'(word_cnt_o), 32'(m_words));
        chk("checksum", checksum_o, m_csum);
        chk("drop_cnt", 32'(drop_cnt_o), 32'(m_drops > 255 ? 255 : m_drops));
        chk("overflow", 32'(overflow_o), 32'(m_ovf));
        chk("load_busy", 32'(load_busy_o), 32'(exp_q.size() != 0));
        chk("cpu_rst", 32'(cpu_rst_o), 32'(m_held));
    endtask

    task automatic idle(input logic acc);
        step(4'h0, 32'h0, 32'h0, acc, 1'b0);
    endtask

    task automatic drain();
        for (int i = 0; i < 20 && exp_q.size() != 0; i++) idle(1'b1);
        idle(1'b1);
        chk("drain_busy", 32'(load_busy_o), 32'd0);
        chk("drain_wr", 32'(mem_wr_o), 32'd0);
    endtask

    task automatic do_reset();
        @(negedge clk_i);
        rst_i = 1'b0;
        tb_inst_we_i = '0; tb_inst_addr_i = '0; tb_inst_data_i = '0;
        rst_cpu_i = 1'b0; mem_accept_i = 1'b0;
        exp_q.delete();
        m_words = '0; m_csum = '0; m_drops = 0; m_ovf = 1'b0; m_held = 1'b1; prev_stall = 1'b0;
        @(negedge clk_i);
        chk("rst_wr", 32'(mem_wr_o), 32'd0);
        chk("rst_addr", mem_addr_o, 32'd0);
        chk("rst_data", mem_data_o, 32'd0);
        chk("rst_be", 32'(mem_be_o), 32'd0);
        chk("rst_cpu", 32'(cpu_rst_o), 32'd1);
        chk("rst_busy", 32'(load_busy_o), 32'd0);
        chk("rst_words", 32'(word_cnt_o), 32'd0);
        chk("rst_csum", checksum_o, 32'd0);
        chk("rst_drops", 32'(drop_cnt_o), 32'd0);
        chk("rst_ovf", 32'(overflow_o), 32'd0);
        @(posedge clk_i);
        #1;
        rst_i = 1'b1;
        chk("release_cpu_rst", 32'(cpu_rst_o), 32'd1);
    endtask

    initial begin
        logic [3:0]  we;
        logic [31:0] addr;

        do_reset();
        idle(1'b0);
        idle(1'b0);
        chk("release_within_2", 32'(cpu_rst_o), 32'd0);

        step(4'hF, 32'h10, 32'hDEADBEEF, 1'b1, 1'b0);
        idle(1'b1);
        chk("lat1_wr", 32'(s_wr), 32'd0);
        idle(1'b1);
        chk("lat2_wr", 32'(s_wr), 32'd1);
        chk("lat2_addr", s_addr, 32'h10);
        chk("single_words", 32'(word_cnt_o), 32'd1);
        chk("single_csum", checksum_o, 32'hDEADBEEF);

        do_reset();
        step(4'hF, 32'h0001_0000, 32'h1234_5678, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) begin
            idle(1'b1);
            chk("oor_no_wr", 32'(s_wr), 32'd0);
        end
        chk("oor_drops", 32'(drop_cnt_o), 32'd1);
        chk("oor_ovf", 32'(overflow_o), 32'd0);
        step(4'h1, 32'h0000_FFFF, 32'h0000_00A5, 1'b1, 1'b0);
        chk("top_edge_words", 32'(word_cnt_o), 32'd1);
        drain();

        do_reset();
        for (int i = 0; i < 6; i++) step(4'hF, 32'(i * 4), $urandom, 1'b0, 1'b0);
        chk("bp_drops", 32'(drop_cnt_o), 32'd2);
        chk("bp_ovf", 32'(overflow_o), 32'd1);
        chk("bp_words", 32'(word_cnt_o), 32'd4);
        for (int i = 0; i < 3; i++) idle(1'b0);
        chk("bp_head_addr", s_addr, 32'h0);
        drain();

        do_reset();
        idle(1'b0);
        idle(1'b0);
        for (int i = 0; i < 3; i++) step(4'hF, 32'h100 + 32'(i * 4), $urandom, 1'b0, 1'b0);
        step(4'h0, 32'h0, 32'h0, 1'b0, 1'b1);
        chk("hold_set", 32'(cpu_rst_o), 32'd1);
        for (int i = 0; i < 20 && exp_q.size() != 0; i++) begin
            idle(i[0]);
            chk("hold_during", 32'(cpu_rst_o), 32'd1);
        end
        idle(1'b1);
        chk("hold_release", 32'(cpu_rst_o), 32'd0);

        do_reset();
        for (int i = 1; i <= 8; i++) step(4'hF, 32'((i - 1) * 4), 32'(i), 1'b1, 1'b0);
        drain();
        chk("cs_sum", checksum_o, 32'h8);
        chk("cs_words", 32'(word_cnt_o), 32'd8);
        chk("cs_drops", 32'(drop_cnt_o), 32'd0);

        do_reset();
        for (int i = 0; i < 260; i++) step(4'h3, 32'h8000_0000, 32'h0, 1'b1, 1'b0);
        chk("drop_saturate", 32'(drop_cnt_o), 32'd255);
        chk("sat_ovf", 32'(overflow_o), 32'd0);

        do_reset();
        for (int i = 0; i < 400; i++) begin
            we   = ($urandom_range(0, 2) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
            addr = ($urandom_range(0, 7) == 0) ? 32'h0001_0000 + $urandom_range(0, 255) * 4
                                               : 32'($urandom_range(0, 32'h0000_FFFF));
            step(we, addr, $urandom, 1'($urandom_range(0, 1)), $urandom_range(0, 40) == 0);
        end
        drain();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
